// File: rtl/sr_stack_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// sr_stack_ctrl_pkg
// Shared definitions for the supervisor stack engine: FSM state encoding,
// push/pop op codes and the default SR-file geometry (SSP index, empty value).
// -----------------------------------------------------------------------------
package sr_stack_ctrl_pkg;

   localparam int unsigned ADDR_W_DEF      = 48;
   localparam int unsigned SR_IDX_W_DEF    = 2;
   localparam int unsigned SSP_IDX_DEF     = 1;
   localparam logic [47:0] STACK_TOP_DEF   = 48'h000000000FFF;
   localparam logic [47:0] STACK_LIMIT_DEF = 48'h000000000000;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_MEM  = 2'd1,
      S_WB   = 2'd2,
      S_RESP = 2'd3
   } state_e;

   typedef enum logic {
      OP_PUSH = 1'b0,
      OP_POP  = 1'b1
   } op_e;

endpackage

// File: rtl/sr_stack_ctrl.sv
// -----------------------------------------------------------------------------
// sr_stack_ctrl
// Stack engine owning the supervisor stack pointer (SSP) in the SR file.
// A push/pop request is accepted in S_IDLE, SSP is sampled from the SR read
// port, bounds are checked, the data-memory access is performed, the updated
// SSP is written back for one cycle, and a response is held until consumed.
//
// Ports
//   iw_clk / iw_rst         clock, asynchronous active-high reset
//   iw_req_* / ow_req_ready request handshake (op 0=push, 1=pop)
//   ow_resp_* / iw_resp_ready response handshake (data, overflow/underflow err)
//   ow_sr_read_addr / iw_sr_read_data   SR read port (always SSP)
//   ow_sr_write_*           SR write port (one-cycle SSP write strobe)
//   ow_mem_* / iw_mem_*     data-memory port, request held until ack
// -----------------------------------------------------------------------------
module sr_stack_ctrl
   import sr_stack_ctrl_pkg::*;
#(
   parameter int unsigned        ADDR_W      = ADDR_W_DEF,
   parameter int unsigned        SR_IDX_W    = SR_IDX_W_DEF,
   parameter int unsigned        SSP_IDX     = SSP_IDX_DEF,
   parameter logic [ADDR_W-1:0]  STACK_TOP   = ADDR_W'(STACK_TOP_DEF),
   parameter logic [ADDR_W-1:0]  STACK_LIMIT = ADDR_W'(STACK_LIMIT_DEF)
) (
   input  logic                iw_clk,
   input  logic                iw_rst,
   input  logic                iw_req_valid,
   output logic                ow_req_ready,
   input  logic                iw_req_op,
   input  logic [ADDR_W-1:0]   iw_req_data,
   output logic                ow_resp_valid,
   input  logic                iw_resp_ready,
   output logic [ADDR_W-1:0]   ow_resp_data,
   output logic                ow_resp_err,
   output logic [SR_IDX_W-1:0] ow_sr_read_addr,
   input  logic [ADDR_W-1:0]   iw_sr_read_data,
   output logic [SR_IDX_W-1:0] ow_sr_write_addr,
   output logic [ADDR_W-1:0]   ow_sr_write_data,
   output logic                ow_sr_write_enable,
   output logic                ow_mem_req,
   output logic                ow_mem_we,
   output logic [ADDR_W-1:0]   ow_mem_addr,
   output logic [ADDR_W-1:0]   ow_mem_wdata,
   input  logic                iw_mem_ack,
   input  logic [ADDR_W-1:0]   iw_mem_rdata
);

   state_e              state_q;
   op_e                 op_q;
   logic [ADDR_W-1:0]   ssp_q;
   logic                resp_valid_q;
   logic                resp_err_q;
   logic [ADDR_W-1:0]   resp_data_q;
   logic                sr_we_q;
   logic [ADDR_W-1:0]   sr_wdata_q;
   logic                mem_req_q;
   logic                mem_we_q;
   logic [ADDR_W-1:0]   mem_addr_q;
   logic [ADDR_W-1:0]   mem_wdata_q;

   // Single shared incrementer/decrementer. In S_IDLE it works on the live SR
   // read data (push address = SSP-1); afterwards on the latched SSP to form
   // the write-back value.
   logic                adj_pop;
   logic [ADDR_W-1:0]   adj_in;
   logic [ADDR_W-1:0]   ssp_adj;

   always_comb begin
      adj_in  = ssp_q;
      adj_pop = (op_q == OP_POP);
      if (state_q == S_IDLE) begin
         adj_in  = iw_sr_read_data;
         adj_pop = iw_req_op;
      end
      ssp_adj = adj_pop ? (adj_in + ADDR_W'(1)) : (adj_in - ADDR_W'(1));
   end

   always_ff @(posedge iw_clk or posedge iw_rst) begin
      if (iw_rst) begin
         state_q      <= S_IDLE;
         op_q         <= OP_PUSH;
         ssp_q        <= '0;
         resp_valid_q <= 1'b0;
         resp_err_q   <= 1'b0;
         resp_data_q  <= '0;
         sr_we_q      <= 1'b0;
         sr_wdata_q   <= '0;
         mem_req_q    <= 1'b0;
         mem_we_q     <= 1'b0;
         mem_addr_q   <= '0;
         mem_wdata_q  <= '0;
      end else begin
         sr_we_q <= 1'b0;
         unique case (state_q)
            S_IDLE: begin
               if (iw_req_valid) begin
                  op_q        <= op_e'(iw_req_op);
                  ssp_q       <= iw_sr_read_data;
                  resp_data_q <= '0;
                  resp_err_q  <= 1'b0;
                  if ((iw_req_op == OP_PUSH && iw_sr_read_data == STACK_LIMIT) ||
                      (iw_req_op == OP_POP  && iw_sr_read_data == STACK_TOP)) begin
                     // Bounds violation: skip memory and SSP update entirely.
                     resp_err_q   <= 1'b1;
                     resp_valid_q <= 1'b1;
                     state_q      <= S_RESP;
                  end else begin
                     mem_req_q <= 1'b1;
                     if (iw_req_op == OP_PUSH) begin
                        mem_we_q    <= 1'b1;
                        mem_addr_q  <= ssp_adj;
                        mem_wdata_q <= iw_req_data;
                     end else begin
                        mem_we_q    <= 1'b0;
                        mem_addr_q  <= iw_sr_read_data;
                        mem_wdata_q <= '0;
                     end
                     state_q <= S_MEM;
                  end
               end
            end
            S_MEM: begin
               if (iw_mem_ack) begin
                  mem_req_q <= 1'b0;
                  if (op_q == OP_POP) begin
                     resp_data_q <= iw_mem_rdata;
                  end
                  sr_we_q    <= 1'b1;
                  sr_wdata_q <= ssp_adj;
                  state_q    <= S_WB;
               end
            end
            S_WB: begin
               resp_valid_q <= 1'b1;
               state_q      <= S_RESP;
            end
            S_RESP: begin
               if (iw_resp_ready) begin
                  resp_valid_q <= 1'b0;
                  state_q      <= S_IDLE;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign ow_req_ready       = (state_q == S_IDLE);
   assign ow_resp_valid      = resp_valid_q;
   assign ow_resp_data       = resp_data_q;
   assign ow_resp_err        = resp_err_q;
   assign ow_sr_read_addr    = SR_IDX_W'(SSP_IDX);
   assign ow_sr_write_addr   = SR_IDX_W'(SSP_IDX);
   assign ow_sr_write_data   = sr_wdata_q;
   assign ow_sr_write_enable = sr_we_q;
   assign ow_mem_req         = mem_req_q;
   assign ow_mem_we          = mem_we_q;
   assign ow_mem_addr        = mem_addr_q;
   assign ow_mem_wdata       = mem_wdata_q;

endmodule

// File: tb/tb_sr_stack_ctrl.sv
// -----------------------------------------------------------------------------
// tb_sr_stack_ctrl
// Bench for sr_stack_ctrl with an SR-file model, a memory responder with
// programmable ack delay, and a reference stack producing expected responses.
// -----------------------------------------------------------------------------
module tb_sr_stack_ctrl;
   import sr_stack_ctrl_pkg::*;

   localparam logic [47:0] TOP = 48'h000000000FFF;

   logic        iw_clk = 1'b0;
   logic        iw_rst = 1'b1;
   logic        iw_req_valid = 1'b0;
   logic        ow_req_ready;
   logic        iw_req_op = 1'b0;
   logic [47:0] iw_req_data = '0;
   logic        ow_resp_valid;
   logic        iw_resp_ready = 1'b0;
   logic [47:0] ow_resp_data;
   logic        ow_resp_err;
   logic [1:0]  ow_sr_read_addr;
   logic [47:0] iw_sr_read_data;
   logic [1:0]  ow_sr_write_addr;
   logic [47:0] ow_sr_write_data;
   logic        ow_sr_write_enable;
   logic        ow_mem_req;
   logic        ow_mem_we;
   logic [47:0] ow_mem_addr;
   logic [47:0] ow_mem_wdata;
   logic        iw_mem_ack = 1'b0;
   logic [47:0] iw_mem_rdata = '0;

   always #5 iw_clk = ~iw_clk;

   sr_stack_ctrl dut (
      .iw_clk             (iw_clk),
      .iw_rst             (iw_rst),
      .iw_req_valid       (iw_req_valid),
      .ow_req_ready       (ow_req_ready),
      .iw_req_op          (iw_req_op),
      .iw_req_data        (iw_req_data),
      .ow_resp_valid      (ow_resp_valid),
      .iw_resp_ready      (iw_resp_ready),
      .ow_resp_data       (ow_resp_data),
      .ow_resp_err        (ow_resp_err),
      .ow_sr_read_addr    (ow_sr_read_addr),
      .iw_sr_read_data    (iw_sr_read_data),
      .ow_sr_write_addr   (ow_sr_write_addr),
      .ow_sr_write_data   (ow_sr_write_data),
      .ow_sr_write_enable (ow_sr_write_enable),
      .ow_mem_req         (ow_mem_req),
      .ow_mem_we          (ow_mem_we),
      .ow_mem_addr        (ow_mem_addr),
      .ow_mem_wdata       (ow_mem_wdata),
      .iw_mem_ack         (iw_mem_ack),
      .iw_mem_rdata       (iw_mem_rdata)
   );

   // SR file model: SSP register, writable by the DUT or forced by the bench.
   logic [47:0] sr_ssp = '0;
   logic        sr_force = 1'b0;
   logic [47:0] sr_force_val = '0;

   always @(posedge iw_clk) begin
      if (sr_force) sr_ssp <= sr_force_val;
      else if (ow_sr_write_enable && ow_sr_write_addr == 2'd1) sr_ssp <= ow_sr_write_data;
   end
   assign iw_sr_read_data = (ow_sr_read_addr == 2'd1) ? sr_ssp : 48'h0;

   // Memory responder: ack after ack_delay waiting cycles, one cycle wide.
   logic [47:0] mem_m [0:4095];
   int ack_delay = 0;
   int wait_cnt  = 0;

   always @(negedge iw_clk) begin
      if (iw_rst) begin
         iw_mem_ack <= 1'b0;
         wait_cnt   <= 0;
      end else if (iw_mem_ack) begin
         iw_mem_ack <= 1'b0;
      end else if (ow_mem_req) begin
         if (wait_cnt >= ack_delay) begin
            iw_mem_ack <= 1'b1;
            wait_cnt   <= 0;
            if (ow_mem_we) mem_m[ow_mem_addr[11:0]] <= ow_mem_wdata;
            else iw_mem_rdata <= mem_m[ow_mem_addr[11:0]];
         end else begin
            wait_cnt <= wait_cnt + 1;
         end
      end
   end

   // Monitors: event counters, last completed memory access, request stability.
   int          sr_we_cnt = 0;
   int          mem_cyc_cnt = 0;
   int          stab_err = 0;
   logic [47:0] last_addr = '0;
   logic [47:0] last_wdata = '0;
   logic        last_we = 1'b0;
   logic        prev_req = 1'b0;
   logic [96:0] prev_bus = '0;

   always @(posedge iw_clk) begin
      if (ow_sr_write_enable) sr_we_cnt <= sr_we_cnt + 1;
      if (ow_mem_req) mem_cyc_cnt <= mem_cyc_cnt + 1;
      if (ow_mem_req && iw_mem_ack) begin
         last_addr  <= ow_mem_addr;
         last_wdata <= ow_mem_wdata;
         last_we    <= ow_mem_we;
      end
      if (prev_req && ow_mem_req && prev_bus != {ow_mem_we, ow_mem_addr, ow_mem_wdata})
         stab_err <= stab_err + 1;
      prev_req <= ow_mem_req && !iw_mem_ack && !iw_rst;
      prev_bus <= {ow_mem_we, ow_mem_addr, ow_mem_wdata};
   end

   // Scoreboard and reference stack.
   typedef struct packed {
      logic [47:0] data;
      logic        err;
   } resp_t;

   resp_t       sb[$];
   logic [47:0] ref_stk[$];
   logic [47:0] ref_ssp = TOP;
   int          n_total = 0;
   int          n_bad = 0;

   task automatic set_ssp(input logic [47:0] v);
      @(negedge iw_clk);
      sr_force = 1'b1;
      sr_force_val = v;
      @(posedge iw_clk);
      #1 sr_force = 1'b0;
   endtask

   task automatic issue(input logic op, input logic [47:0] d);
      resp_t e;
      e.err = 1'b0;
      e.data = '0;
      if (op == 1'b0) begin
         if (ref_ssp == 48'h0) e.err = 1'b1;
         else begin
            ref_ssp = ref_ssp - 48'h1;
            ref_stk.push_back(d);
         end
      end else begin
         if (ref_ssp == TOP) e.err = 1'b1;
         else begin
            e.data = ref_stk.pop_back();
            ref_ssp = ref_ssp + 48'h1;
         end
      end
      sb.push_back(e);
      @(negedge iw_clk);
      iw_req_valid = 1'b1;
      iw_req_op = op;
      iw_req_data = d;
      @(posedge iw_clk);
      #1 iw_req_valid = 1'b0;
   endtask

   task automatic collect(input int rdly, output resp_t got, output int lat,
                          output bit held_ok, output bit ready_bad, output bit tmo);
      lat = 0; held_ok = 1'b1; ready_bad = 1'b0; tmo = 1'b0; got = '0;
      while (1) begin
         @(negedge iw_clk);
         lat++;
         if (ow_resp_valid) break;
         if (ow_req_ready) ready_bad = 1'b1;
         if (lat > 200) begin
            tmo = 1'b1;
            return;
         end
      end
      got.data = ow_resp_data;
      got.err  = ow_resp_err;
      for (int k = 0; k < rdly; k++) begin
         @(negedge iw_clk);
         if (!ow_resp_valid || ow_resp_data !== got.data || ow_resp_err !== got.err)
            held_ok = 1'b0;
         if (ow_req_ready) ready_bad = 1'b1;
      end
      iw_resp_ready = 1'b1;
      @(posedge iw_clk);
      #1 iw_resp_ready = 1'b0;
   endtask

   task automatic test_reset();
      iw_rst = 1'b1;
      set_ssp(TOP);
      @(negedge iw_clk);
      n_total++; if (ow_resp_valid !== 1'b0) begin n_bad++;
         $display("FAIL reset_resp_valid got=%b exp=0", ow_resp_valid); end
      n_total++; if (ow_mem_req !== 1'b0 || ow_mem_addr !== 48'h0) begin n_bad++;
         $display("FAIL reset_mem got=%b/%h exp=0/0", ow_mem_req, ow_mem_addr); end
      n_total++; if (ow_sr_write_enable !== 1'b0 || ow_resp_data !== 48'h0) begin n_bad++;
         $display("FAIL reset_sr_resp got=%b/%h exp=0/0", ow_sr_write_enable, ow_resp_data); end
      iw_rst = 1'b0;
      @(negedge iw_clk);
      n_total++; if (ow_req_ready !== 1'b1) begin n_bad++;
         $display("FAIL reset_req_ready got=%b exp=1", ow_req_ready); end
   endtask

   task automatic test_push();
      resp_t got, exp;
      int lat, we0;
      bit held, rbad, tmo;
      we0 = sr_we_cnt;
      issue(1'b0, 48'h123);
      collect(0, got, lat, held, rbad, tmo);
      exp = sb.pop_front();
      n_total++; if (tmo || got !== exp) begin n_bad++;
         $display("FAIL push_resp got=%h/%b exp=%h/%b tmo=%0d", got.data, got.err,
                  exp.data, exp.err, tmo); end
      n_total++; if (last_addr !== 48'hFFE || last_we !== 1'b1) begin n_bad++;
         $display("FAIL push_mem_addr got=%h/%b exp=ffe/1", last_addr, last_we); end
      n_total++; if (last_wdata !== 48'h123) begin n_bad++;
         $display("FAIL push_mem_wdata got=%h exp=123", last_wdata); end
      n_total++; if (sr_ssp !== ref_ssp) begin n_bad++;
         $display("FAIL push_ssp got=%h exp=%h", sr_ssp, ref_ssp); end
      n_total++; if (sr_we_cnt - we0 != 1) begin n_bad++;
         $display("FAIL push_sr_writes got=%0d exp=1", sr_we_cnt - we0); end
   endtask

   task automatic test_pop();
      resp_t got, exp;
      int lat;
      bit held, rbad, tmo;
      issue(1'b1, 48'h0);
      collect(0, got, lat, held, rbad, tmo);
      exp = sb.pop_front();
      n_total++; if (tmo || got !== exp) begin n_bad++;
         $display("FAIL pop_resp got=%h/%b exp=%h/%b tmo=%0d", got.data, got.err,
                  exp.data, exp.err, tmo); end
      n_total++; if (last_addr !== 48'hFFE || last_we !== 1'b0) begin n_bad++;
         $display("FAIL pop_mem_addr got=%h/%b exp=ffe/0", last_addr, last_we); end
      n_total++; if (sr_ssp !== TOP || sr_ssp !== ref_ssp) begin n_bad++;
         $display("FAIL pop_ssp got=%h exp=%h", sr_ssp, ref_ssp); end
   endtask

   task automatic test_underflow();
      resp_t got, exp;
      int lat, we0, mc0;
      bit held, rbad, tmo;
      we0 = sr_we_cnt; mc0 = mem_cyc_cnt;
      issue(1'b1, 48'h0);
      collect(0, got, lat, held, rbad, tmo);
      exp = sb.pop_front();
      n_total++; if (tmo || got !== exp || got.err !== 1'b1 || got.data !== 48'h0) begin
         n_bad++;
         $display("FAIL underflow_resp got=%h/%b exp=%h/%b", got.data, got.err,
                  exp.data, exp.err); end
      n_total++; if (mem_cyc_cnt != mc0 || sr_we_cnt != we0) begin n_bad++;
         $display("FAIL underflow_side got=mem%0d/sr%0d exp=0/0", mem_cyc_cnt - mc0,
                  sr_we_cnt - we0); end
   endtask

   task automatic test_overflow();
      resp_t got, exp;
      int lat, we0, mc0;
      bit held, rbad, tmo;
      set_ssp(48'h0);
      ref_ssp = 48'h0;
      we0 = sr_we_cnt; mc0 = mem_cyc_cnt;
      issue(1'b0, 48'h77);
      collect(0, got, lat, held, rbad, tmo);
      exp = sb.pop_front();
      n_total++; if (tmo || got !== exp || got.err !== 1'b1) begin n_bad++;
         $display("FAIL overflow_resp got=%h/%b exp=%h/%b", got.data, got.err,
                  exp.data, exp.err); end
      n_total++; if (mem_cyc_cnt != mc0 || sr_we_cnt != we0 || sr_ssp !== 48'h0) begin
         n_bad++;
         $display("FAIL overflow_side got=mem%0d/sr%0d/ssp%h exp=0/0/0",
                  mem_cyc_cnt - mc0, sr_we_cnt - we0, sr_ssp); end
      set_ssp(TOP);
      ref_ssp = TOP;
   endtask

   task automatic test_backpressure();
      resp_t got, exp;
      int lat, mc0, se0;
      bit held, rbad, tmo;
      ack_delay = 5;
      for (int i = 0; i < 2; i++) begin
         mc0 = mem_cyc_cnt; se0 = stab_err;
         issue(i[0], 48'hABC);
         collect(3, got, lat, held, rbad, tmo);
         exp = sb.pop_front();
         n_total++; if (tmo || got !== exp) begin n_bad++;
            $display("FAIL bp_resp[%0d] got=%h/%b exp=%h/%b", i, got.data, got.err,
                     exp.data, exp.err); end
         n_total++; if (stab_err != se0 || mem_cyc_cnt - mc0 != 6) begin n_bad++;
            $display("FAIL bp_mem[%0d] got=unstable%0d/cycles%0d exp=0/6", i,
                     stab_err - se0, mem_cyc_cnt - mc0); end
         n_total++; if (!held || rbad) begin n_bad++;
            $display("FAIL bp_hold[%0d] got=held%0d/ready_early%0d exp=1/0", i, held, rbad); end
      end
      ack_delay = 0;
   endtask

   task automatic test_back_to_back();
      logic        ops [4];
      logic [47:0] dat [4];
      resp_t got, exp;
      int lat;
      bit held, rbad, tmo;
      ops = '{1'b0, 1'b0, 1'b1, 1'b1};
      dat = '{48'h111, 48'h222, 48'h0, 48'h0};
      for (int i = 0; i < 4; i++) begin
         issue(ops[i], dat[i]);
         collect(0, got, lat, held, rbad, tmo);
         exp = sb.pop_front();
         n_total++; if (tmo || got !== exp || lat != 3) begin n_bad++;
            $display("FAIL b2b[%0d] got=%h/%b lat%0d exp=%h/%b lat3", i, got.data, got.err,
                     lat, exp.data, exp.err); end
      end
      n_total++; if (sr_ssp !== ref_ssp) begin n_bad++;
         $display("FAIL b2b_ssp got=%h exp=%h", sr_ssp, ref_ssp); end
   endtask

   task automatic test_reset_mid_op();
      logic [47:0] saved;
      logic [47:0] dummy;
      resp_t got, exp;
      int lat, we0;
      bit held, rbad, tmo;
      ack_delay = 100;
      saved = ref_ssp;
      we0 = sr_we_cnt;
      issue(1'b0, 48'h55);
      @(negedge iw_clk);
      n_total++; if (ow_mem_req !== 1'b1) begin n_bad++;
         $display("FAIL rst_mid_busy got=%b exp=1", ow_mem_req); end
      #1 iw_rst = 1'b1;
      #1;
      n_total++; if (ow_mem_req !== 1'b0) begin n_bad++;
         $display("FAIL rst_mid_mem_req got=%b exp=0", ow_mem_req); end
      @(negedge iw_clk);
      iw_rst = 1'b0;
      sb.delete();
      ref_ssp = saved;
      dummy = ref_stk.pop_back();
      ack_delay = 0;
      @(negedge iw_clk);
      n_total++; if (ow_req_ready !== 1'b1 || ow_resp_valid !== 1'b0) begin n_bad++;
         $display("FAIL rst_mid_idle got=%b/%b exp=1/0", ow_req_ready, ow_resp_valid); end
      n_total++; if (sr_we_cnt != we0 || sr_ssp !== saved) begin n_bad++;
         $display("FAIL rst_mid_no_wb got=%0d/%h exp=0/%h", sr_we_cnt - we0, sr_ssp, saved); end
      issue(1'b1, 48'h0);
      collect(0, got, lat, held, rbad, tmo);
      exp = sb.pop_front();
      n_total++; if (tmo || got !== exp) begin n_bad++;
         $display("FAIL rst_mid_recover got=%h/%b exp=%h/%b", got.data, got.err,
                  exp.data, exp.err); end
   endtask

   initial begin
      test_reset();
      test_push();
      test_pop();
      test_underflow();
      test_overflow();
      test_backpressure();
      test_back_to_back();
      test_reset_mid_op();
      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule

// File: doc/sr_stack_ctrl.md
Name: sr_stack_ctrl

Overview:
Stack engine that owns the supervisor stack pointer (SSP) held in the special-register file. It accepts push/pop requests over a valid/ready handshake and reads SSP through an SR read port. It performs the memory access, then writes the updated SSP back through the SR write port. It is the initiator/writer on the SR register file interface and sits between the execute stage and the data-memory port.

Parameters:
ADDR_W, 48, width of addresses, SSP and stack data words
SR_IDX_W, 2, width of SR index (matches SR file target width)
SSP_IDX, 1, SR index of SSP
STACK_TOP, 48'h000000000FFF, SSP value meaning "stack empty" (SR file reset value of SSP)
STACK_LIMIT, 48'h000000000000, lowest legal SSP; a push with SSP at this value overflows

Ports:
iw_clk  in  1  clock
iw_rst  in  1  reset, asynchronous, active-high
iw_req_valid  in  1  request valid
ow_req_ready  out  1  request accepted when valid&ready
iw_req_op  in  1  0=push, 1=pop
iw_req_data  in  ADDR_W  push data (ignored for pop)
ow_resp_valid  out  1  response valid, held until iw_resp_ready
iw_resp_ready  in  1  response consumed
ow_resp_data  out  ADDR_W  popped word; 0 for push or error
ow_resp_err  out  1  1 = overflow (push) or underflow (pop)
ow_sr_read_addr  out  SR_IDX_W  constant SSP_IDX
iw_sr_read_data  in  ADDR_W  combinational SR read data (SSP)
ow_sr_write_addr  out  SR_IDX_W  constant SSP_IDX
ow_sr_write_data  out  ADDR_W  new SSP
ow_sr_write_enable  out  1  one-cycle SSP write strobe
ow_mem_req  out  1  memory request, held until iw_mem_ack
ow_mem_we  out  1  1=write (push), 0=read (pop)
ow_mem_addr  out  ADDR_W  word address
ow_mem_wdata  out  ADDR_W  push data
iw_mem_ack  in  1  memory completion; rdata valid same cycle for reads
iw_mem_rdata  in  ADDR_W  read data

Behaviour:
- Reset (async, any state): state=S_IDLE; ow_resp_valid=0, ow_resp_err=0, ow_resp_data=0, ow_mem_req=0, ow_mem_we=0, ow_mem_addr=0, ow_mem_wdata=0, ow_sr_write_enable=0, ow_sr_write_data=0. ow_req_ready=1 once reset deasserts. A transaction in flight at reset is abandoned; SSP is not written.
- ow_req_ready = (state==S_IDLE), combinational.
- S_IDLE: on valid&ready, latch op, data and iw_sr_read_data into r_ssp.
  - Push, r_ssp==STACK_LIMIT: error -> S_RESP, err=1.
  - Pop, r_ssp==STACK_TOP: error -> S_RESP, err=1.
  - Push otherwise: mem_addr=r_ssp-1 (mod 2^ADDR_W), we=1, wdata=data -> S_MEM.
  - Pop otherwise: mem_addr=r_ssp, we=0 -> S_MEM.
- S_MEM: ow_mem_req=1 and address/we/wdata stable until iw_mem_ack. On ack: pop captures iw_mem_rdata into resp_data -> S_WB. Ack in the first S_MEM cycle is legal.
- S_WB: exactly one cycle of ow_sr_write_enable=1. write_data = r_ssp-1 (push) or r_ssp+1 (pop). -> S_RESP.
- S_RESP: ow_resp_valid=1, data and err stable; on iw_resp_ready -> S_IDLE. No SR write and no memory request occur on the error path.
- Minimum latency with immediate ack and ready: accept at cycle 0, mem_req at 1, SR write at 2, resp_valid at 3, next accept at 4.
- SSP is re-read at every accept, so a back-to-back request sees the value written in S_WB (SR write visible from the next cycle).
- The block is the sole SSP writer while not in S_IDLE; arbitration of other SR writers is external.
- Arithmetic is ADDR_W-bit unsigned. No wrap occurs in legal operation because the limit checks precede every decrement or increment.

Decomposition:
- Shared package/header: state encoding (S_IDLE, S_MEM, S_WB, S_RESP), op codes (OP_PUSH=0, OP_POP=1), default SSP_IDX and STACK_TOP, reused from the existing sizes/SR headers.
- Single module; no sub-module. Datapath is one adder/subtractor and the registers.

Test Plan:
- Push after reset: SSP=0xFFF, push 0x123 -> mem write addr 0xFFE, data 0x123; SR write SSP=0xFFE; resp err=0, data=0.
- Pop after that push: SSP=0xFFE, mem rdata 0x123 -> mem read addr 0xFFE; SR write SSP=0xFFF; resp data=0x123, err=0.
- Underflow: pop with SSP=0xFFF -> no mem_req, no sr_write_enable; resp err=1, data=0.
- Overflow: push with SSP=0x000 -> no mem_req, no SR write; resp err=1.
- Backpressure: mem_ack delayed 5 cycles and resp_ready delayed 3 cycles -> mem_req, addr and wdata stable throughout; resp_valid held; req_ready=0 until resp consumed.
- Reset mid-op: assert iw_rst while in S_MEM -> mem_req=0 immediately; no SR write; req_ready=1 after release.
